pixel_data_memory: RTL and testbench

Memory stage of the filter GPU, directly downstream of the datapath's execute/memory buffer. It consumes A1M/A2M/A3M, writeDataM and MemWriteM, and returns the three-lane RDM word to the writeback buffer. It also owns an external image-load stream that fills the memory and a dump stream that reads it out. While either stream runs, it raises busy so the hazard logic stalls the pipeline.

---
 rtl/gpu_mem_pkg.sv | 22 ++
 rtl/mem_stream_fsm.sv | 105 ++++++++++
 rtl/pixel_data_memory.sv | 80 ++++++++
 tb/tb_pixel_data_memory.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared types and sizes for the filter GPU pixel memory stage.
// Lane i of a vector is paired with address A(i+1)M.
package gpu_mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 18;
  localparam int LANES  = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef pixel_t [LANES-1:0] lane_vec_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    MS_RUN,
    MS_LOAD,
    MS_DUMP
  } mem_state_t;

  localparam addr_t ADDR_LAST = addr_t'(DEPTH - 1);

endpackage

// File: rtl/mem_stream_fsm.sv
// Load/dump stream sequencer: state, stream counters, handshakes and
// array write-enable selection. Dump path is built only with DMEM_DUMP_EN.
module mem_stream_fsm
  import gpu_mem_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  mem_write,
  input  logic  ld_start,
  input  logic  ld_valid,
  input  logic  ld_last,
  input  logic  dp_start,
  input  logic  dp_ready,
  output logic  busy,
  output logic  ld_ready,
  output logic  dp_valid,
  output logic  dp_done,
  output logic  st_we,
  output logic  ld_we,
  output addr_t ld_addr,
  output addr_t dp_addr
);

  mem_state_t state, state_nx;
  addr_t      ld_cnt, ld_cnt_nx;
  addr_t      dp_cnt, dp_cnt_nx;
  logic       done_q, done_nx;

  // state and stream counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MS_RUN;
      ld_cnt <= '0;
      dp_cnt <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      ld_cnt <= ld_cnt_nx;
      dp_cnt <= dp_cnt_nx;
      done_q <= done_nx;
    end
  end

  // next state, counter steps, handshakes and write-enable mux
  always_comb begin
    state_nx  = state;
    ld_cnt_nx = ld_cnt;
    dp_cnt_nx = dp_cnt;
    done_nx   = 1'b0;
    ld_ready  = 1'b0;
    dp_valid  = 1'b0;
    st_we     = 1'b0;
    ld_we     = 1'b0;
    unique case (state)
      MS_RUN: begin
        st_we = mem_write;
        if (ld_start) begin
          state_nx = MS_LOAD;
`ifdef DMEM_DUMP_EN
        end else if (dp_start) begin
          state_nx = MS_DUMP;
`endif
        end
      end
      MS_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          ld_we = 1'b1;
          if (ld_last || ld_cnt == ADDR_LAST) begin
            state_nx  = MS_RUN;
            ld_cnt_nx = '0;
          end else begin
            ld_cnt_nx = ld_cnt + 1'b1;
          end
        end
      end
`ifdef DMEM_DUMP_EN
      MS_DUMP: begin
        dp_valid = 1'b1;
        if (dp_ready) begin
          if (dp_cnt == ADDR_LAST) begin
            state_nx  = MS_RUN;
            dp_cnt_nx = '0;
            done_nx   = 1'b1;
          end else begin
            dp_cnt_nx = dp_cnt + 1'b1;
          end
        end
      end
`endif
      default: state_nx = MS_RUN;
    endcase
  end

`ifndef DMEM_DUMP_EN
  logic unused_dp;
  assign unused_dp = dp_start ^ dp_ready;
`endif

  assign busy    = (state != MS_RUN);
  assign dp_done = done_q;
  assign ld_addr = ld_cnt;
  assign dp_addr = dp_cnt;

endmodule

// File: rtl/pixel_data_memory.sv
// Filter GPU memory stage: 3-lane pixel array with combinational reads,
// image load stream and (with DMEM_DUMP_EN) dump stream.
module pixel_data_memory
  import gpu_mem_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ADDR_W-1:0]        A1M,
  input  logic [ADDR_W-1:0]        A2M,
  input  logic [ADDR_W-1:0]        A3M,
  input  logic [LANES*DATA_W-1:0]  writeDataM,
  input  logic                     MemWriteM,
  output logic [LANES*DATA_W-1:0]  RDM,
  output logic                     busy,
  input  logic                     ld_start,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     ld_last,
  input  logic                     dp_start,
  output logic                     dp_valid,
  input  logic                     dp_ready,
  output logic [DATA_W-1:0]        dp_data,
  output logic                     dp_done
);

  pixel_t    mem [DEPTH];
  lane_vec_t wd;
  lane_vec_t rd;
  logic      st_we;
  logic      ld_we;
  addr_t     ld_addr;
  addr_t     dp_addr;

  mem_stream_fsm u_fsm (
    .clk       (CLK),
    .rst       (RST),
    .mem_write (MemWriteM),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_last   (ld_last),
    .dp_start  (dp_start),
    .dp_ready  (dp_ready),
    .busy      (busy),
    .ld_ready  (ld_ready),
    .dp_valid  (dp_valid),
    .dp_done   (dp_done),
    .st_we     (st_we),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .dp_addr   (dp_addr)
  );

  assign wd = writeDataM;

  // array write; lane 0 is written last so it wins on duplicate addresses
  always_ff @(posedge CLK) begin
    if (st_we) begin
      mem[A3M] <= wd[2];
      mem[A2M] <= wd[1];
      mem[A1M] <= wd[0];
    end else if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign rd[0] = mem[A1M];
  assign rd[1] = mem[A2M];
  assign rd[2] = mem[A3M];
  assign RDM   = rd;

`ifdef DMEM_DUMP_EN
  assign dp_data = mem[dp_addr];
`else
  logic unused_dpa;
  assign unused_dpa = ^dp_addr;
  assign dp_data    = '0;
`endif

endmodule

// File: tb/tb_pixel_data_memory.sv
// Scoreboard bench for pixel_data_memory against an array model.
// Build with DMEM_DUMP_EN defined to exercise the dump stream.
module tb_pixel_data_memory;

  logic        CLK = 1'b0;
  logic        RST;
  logic [9:0]  A1M, A2M, A3M;
  logic [53:0] writeDataM;
  logic        MemWriteM;
  logic [53:0] RDM;
  logic        busy;
  logic        ld_start, ld_valid, ld_ready, ld_last;
  logic [17:0] ld_data;
  logic        dp_start, dp_valid, dp_ready, dp_done;
  logic [17:0] dp_data;

  pixel_data_memory dut (
    .CLK(CLK), .RST(RST),
    .A1M(A1M), .A2M(A2M), .A3M(A3M),
    .writeDataM(writeDataM), .MemWriteM(MemWriteM),
    .RDM(RDM), .busy(busy),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last),
    .dp_start(dp_start), .dp_valid(dp_valid), .dp_ready(dp_ready),
    .dp_data(dp_data), .dp_done(dp_done)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0] model [1024];
  logic [53:0] rd_q [$];
  logic [17:0] dp_q [$];
  logic        rd_chk = 1'b0;
  logic        held_flag = 1'b0;
  logic [17:0] held_val;
  logic        done_exp = 1'b0;
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [53:0] mvec(input logic [9:0] a0,
                                       input logic [9:0] a1,
                                       input logic [9:0] a2);
    return {model[a2], model[a1], model[a0]};
  endfunction

  // scoreboard monitor: reads and dump beats
  always @(negedge CLK) begin
    logic [53:0] ev;
    logic [17:0] ed;
    if (rd_chk) begin
      if (rd_q.size() == 0) fail("rd_underflow");
      else begin
        ev = rd_q.pop_front();
        chk("rdm", RDM, ev);
      end
    end
    if (dp_done === 1'b1) done_cnt++;
    if (done_exp) begin
      chk("dp_done_pulse", dp_done, 1);
      done_exp = 1'b0;
    end
    if (dp_valid === 1'b1) begin
      if (held_flag) chk("dp_hold", dp_data, held_val);
      if (dp_ready) begin
        held_flag = 1'b0;
        if (dp_q.size() == 0) fail("dp_extra_beat");
        else begin
          ed = dp_q.pop_front();
          chk("dp_data", dp_data, ed);
          if (dp_q.size() == 0) done_exp = 1'b1;
        end
      end else begin
        held_flag = 1'b1;
        held_val  = dp_data;
      end
    end else begin
      held_flag = 1'b0;
    end
  end

  task automatic push_read(input logic [9:0] a0, input logic [9:0] a1,
                           input logic [9:0] a2, input logic [53:0] ev);
    A1M = a0; A2M = a1; A3M = a2;
    MemWriteM = 1'b0;
    rd_q.push_back(ev);
    rd_chk = 1'b1;
    tick;
    rd_chk = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a0, input logic [9:0] a1,
                         input logic [9:0] a2);
    push_read(a0, a1, a2, mvec(a0, a1, a2));
  endtask

  // store; the same-cycle read must still see the old contents
  task automatic do_store(input logic [9:0] a0, input logic [9:0] a1,
                          input logic [9:0] a2, input logic [17:0] d0,
                          input logic [17:0] d1, input logic [17:0] d2);
    logic [9:0]  a [3];
    logic [17:0] d [3];
    a[0] = a0; a[1] = a1; a[2] = a2;
    d[0] = d0; d[1] = d1; d[2] = d2;
    A1M = a0; A2M = a1; A3M = a2;
    writeDataM = {d2, d1, d0};
    MemWriteM = 1'b1;
    rd_q.push_back(mvec(a0, a1, a2));
    rd_chk = 1'b1;
    tick;
    rd_chk = 1'b0;
    MemWriteM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit shadow = 1'b0;
      for (int j = 0; j < i; j++)
        if (a[j] == a[i]) shadow = 1'b1;
      if (!shadow) model[a[i]] = d[i];
    end
  endtask

  task automatic do_load(input int n, input bit use_last, input bit fixed_d,
                         input bit both, input bit inject);
    int beats = 0;
    ld_start = 1'b1;
    dp_start = both;
    tick;
    ld_start = 1'b0;
    dp_start = 1'b0;
    while (beats < n) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_data  = fixed_d ? 18'((beats + 1) * 17) : 18'($urandom);
      ld_last  = use_last && (beats == n - 1);
      dp_start = ($urandom_range(0, 7) == 0);
      MemWriteM = inject;
      A1M = 10'($urandom_range(64, 1023));
      A2M = 10'($urandom_range(64, 1023));
      A3M = 10'($urandom_range(64, 1023));
      writeDataM = {18'($urandom), 18'($urandom), 18'($urandom)};
      @(negedge CLK);
      chk("load_ready", ld_ready, 1);
      chk("load_busy", busy, 1);
      chk("load_no_dump", dp_valid, 0);
      @(posedge CLK);
      if (ld_valid) begin
        model[beats] = ld_data;
        beats++;
      end
      #1;
    end
    ld_valid = 1'b0;
    ld_last = 1'b0;
    dp_start = 1'b0;
    MemWriteM = 1'b0;
    @(negedge CLK);
    chk("load_end_busy", busy, 0);
    chk("load_end_ready", ld_ready, 0);
    tick;
  endtask

  initial begin
    logic [9:0] w;
    logic [9:0] ra, rb, rc;
    RST = 1'b1;
    A1M = '0; A2M = '0; A3M = '0;
    writeDataM = '0; MemWriteM = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    dp_start = 1'b0; dp_ready = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_dp_valid", dp_valid, 0);
    chk("rst_dp_done", dp_done, 0);
    tick;
    RST = 1'b0;
    tick;

    // full-depth load ends at the last address without ld_last
    do_load(1024, 1'b0, 1'b0, 1'b0, 1'b0);

    // four fixed beats with ld_last, counter restarts at 0
    do_load(4, 1'b1, 1'b1, 1'b0, 1'b0);
    push_read(10'd1, 10'd2, 10'd0, {18'h00011, 18'h00033, 18'h00022});

    // store with address wrap
    w = 10'd0;
    w = w - 10'd1;
    do_store(10'd0, 10'd1, w, 18'h3FFFF, 18'h00001, 18'h12345);
    push_read(10'd0, 10'd1, 10'd1023, {18'h12345, 18'h00001, 18'h3FFFF});

    // duplicate addresses: lower lane wins
    do_store(10'd5, 10'd5, 10'd7, 18'h00AAA, 18'h00BBB, 18'h00CCC);
    push_read(10'd5, 10'd5, 10'd7, {18'h00CCC, 18'h00AAA, 18'h00AAA});
    do_store(10'd9, 10'd9, 10'd9, 18'h00001, 18'h00002, 18'h00003);
    push_read(10'd9, 10'd9, 10'd9, {18'h00001, 18'h00001, 18'h00001});

    // simultaneous starts: load wins; stores during load are dropped
    do_load(3, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("after_load_idle", busy, 0);
      chk("after_load_no_dump", dp_valid, 0);
      tick;
    end

    // randomized mix of stores, reads and short loads
    ra = 10'd0; rb = 10'd0; rc = 10'd0;
    for (int k = 0; k < 300; k++) begin
      int op = $urandom_range(0, 9);
      if (op < 5) begin
        ra = 10'($urandom);
        rb = ($urandom_range(0, 2) == 0) ? ra : 10'($urandom);
        rc = ($urandom_range(0, 2) == 0) ? rb : 10'($urandom);
        do_store(ra, rb, rc, 18'($urandom), 18'($urandom), 18'($urandom));
      end else if (op < 9) begin
        if ($urandom_range(0, 1) == 0) do_read(rc, ra, rb);
        else do_read(10'($urandom), 10'($urandom_range(0, 8)),
                     10'($urandom));
      end else begin
        do_load($urandom_range(1, 8), 1'b1, 1'b0, 1'b0, 1'b1);
        do_read(10'd0, 10'd1, 10'd7);
      end
    end

`ifdef DMEM_DUMP_EN
    // full dump with back-pressure, stray starts are ignored
    for (int i = 0; i < 1024; i++) dp_q.push_back(model[i]);
    done_cnt = 0;
    dp_start = 1'b1;
    tick;
    dp_start = 1'b0;
    for (int c = 0; c < 6000 && dp_q.size() > 0; c++) begin
      if (c == 0 || c == 3) dp_ready = 1'b1;
      else if (c < 3) dp_ready = 1'b0;
      else dp_ready = ($urandom_range(0, 2) != 0);
      dp_start = ($urandom_range(0, 15) == 0);
      ld_start = ($urandom_range(0, 31) == 0);
      @(negedge CLK);
      if (c == 0) chk("dump_busy", busy, 1);
      @(posedge CLK);
      #1;
    end
    dp_start = 1'b0;
    ld_start = 1'b0;
    dp_ready = 1'b0;
    if (dp_q.size() != 0) begin
      fail("dump_timeout");
      dp_q.delete();
    end
    repeat (3) tick;
    @(negedge CLK);
    chk("dump_done_count", done_cnt, 1);
    chk("dump_end_busy", busy, 0);
    chk("dump_end_valid", dp_valid, 0);
    tick;
`else
    // dump path absent: start is ignored and outputs stay low
    dp_start = 1'b1;
    tick;
    dp_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      dp_ready = 1'($urandom);
      @(negedge CLK);
      chk("nodump_valid", dp_valid, 0);
      chk("nodump_busy", busy, 0);
      chk("nodump_data", dp_data, 0);
      chk("nodump_done", dp_done, 0);
      tick;
    end
    dp_ready = 1'b0;
`endif

    // asynchronous reset in the middle of a load
    ld_start = 1'b1;
    tick;
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_last = 1'b0;
    ld_data = 18'($urandom);
    tick;
    model[0] = ld_data;
    ld_data = 18'($urandom);
    #2;
    RST = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_ld_ready", ld_ready, 0);
    chk("async_dp_valid", dp_valid, 0);
    chk("async_dp_done", dp_done, 0);
    ld_valid = 1'b0;
    tick;
    RST = 1'b0;
    tick;
    do_read(10'd0, 10'd1, 10'd2);
    do_load(2, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read(10'd1, 10'd0, 10'd2);

    tick;
    chk("rd_queue_drained", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
